// File: rtl/lmsm_sequencer_if.sv
// Register-file and data-RAM bus driven by the LM/SM sequencer.
// master = sequencer side, slave = RAM/register-file side.
interface lmsm_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3
);
  logic [IDX_W-1:0]  rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [IDX_W-1:0]  rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_load;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, mem_addr, mem_din, mem_load,
    input  rf_rd_data, mem_dout
  );
  modport slave (
    input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, mem_addr, mem_din, mem_load,
    output rf_rd_data, mem_dout
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple engine: walks a register mask lowest index first,
// one register per cycle. Define LMSM_WRITEBACK_EN to add the base-register writeback state.
module lmsm_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [IDX_W-1:0]  wb_reg,
  lmsm_sequencer_if.master  bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [NREGS-1:0]  r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic              r_op;
  logic [IDX_W-1:0]  w_idx;
  logic [NREGS-1:0]  w_mask_nxt;

`ifdef LMSM_WRITEBACK_EN
  logic [IDX_W-1:0]  r_wb;
  localparam state_t S_FINAL = S_WB;

  always_ff @(posedge clk) begin
    if (!rst_n)                          r_wb <= '0;
    else if (r_state == S_IDLE && start) r_wb <= wb_reg;
  end
`else
  localparam state_t S_FINAL = S_DONE;
  logic w_unused_wb;
  assign w_unused_wb = ^wb_reg;
`endif

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (r_mask[i]) w_idx = IDX_W'(i);
    w_mask_nxt = r_mask & ~(NREGS'(1) << w_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_addr  <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_mask <= reg_mask;
        r_addr <= base_addr;
        r_op   <= is_store;
      end else if (r_state == S_XFER) begin
        r_mask <= w_mask_nxt;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Strobes are ANDed with rst_n so a reset cycle never commits a RAM or RF write.
  always_comb begin
    w_state_nxt    = r_state;
    bus.rf_rd_addr = '0;
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_wr_data = '0;
    bus.mem_addr   = r_addr;
    bus.mem_din    = '0;
    bus.mem_load   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (reg_mask != '0) ? S_XFER : S_FINAL;
      S_XFER: begin
        if (r_op) begin
          bus.rf_rd_addr = w_idx;
          bus.mem_din    = bus.rf_rd_data;
          bus.mem_load   = rst_n;
        end else begin
          bus.rf_wr_en   = rst_n;
          bus.rf_wr_addr = w_idx;
          bus.rf_wr_data = bus.mem_dout;
        end
        if (w_mask_nxt == '0) w_state_nxt = S_FINAL;
      end
`ifdef LMSM_WRITEBACK_EN
      S_WB: begin
        bus.rf_wr_en   = rst_n;
        bus.rf_wr_addr = r_wb;
        bus.rf_wr_data = DATA_W'(r_addr);
        w_state_nxt    = S_DONE;
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
Multi-cycle load-multiple/store-multiple engine that sits directly upstream of the data RAM: it drives the RAM's address, write-data and load strobe, and consumes its asynchronous read data. It takes a base address and an 8-bit register mask from the control path. It then walks the mask lowest-index first, moving one register per cycle between the register file and consecutive RAM words. It pulses done on completion.

Parameters:
DATA_W, 16, data word width (RAM word and register width)
ADDR_W, 16, RAM address width
NREGS, 8, mask width / number of architectural registers
IDX_W, 3, register index width (clog2 NREGS)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin operation; sampled only when busy=0
is_store  input  1  1=SM (reg->mem), 0=LM (mem->reg); latched at start
base_addr  input  ADDR_W  first RAM address; latched at start
reg_mask  input  NREGS  registers to transfer; latched at start
wb_reg  input  IDX_W  base register index for writeback (used only with LMSM_WRITEBACK_EN)
rf_rd_addr  output  IDX_W  register file read index (combinational)
rf_rd_data  input  DATA_W  register file async read data
rf_wr_en  output  1  register file write strobe
rf_wr_addr  output  IDX_W  register file write index
rf_wr_data  output  DATA_W  register file write data
mem_addr  output  ADDR_W  to RAM address
mem_din  output  DATA_W  to RAM write data
mem_load  output  1  to RAM write enable
mem_dout  input  DATA_W  from RAM async read data
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle completion pulse

Behaviour:
- Clock is clk; reset is synchronous, active-low, on rst_n.
- States: IDLE, XFER, (WB with macro), DONE. Reset -> IDLE; regs cleared: mask_r=0, addr_r=0, op_r=0.
- Reset values: busy=0, done=0, mem_load=0, rf_wr_en=0, mem_addr=0, mem_din=0, rf_* indices/data=0.
- mem_load and rf_wr_en are gated with rst_n. They are 0 in any cycle where rst_n=0, including mid-operation.
- IDLE: on start=1, latch is_store, base_addr, reg_mask. If reg_mask!=0 go to XFER, else go to DONE.
- XFER, one transfer per cycle: idx = lowest set bit of mask_r; mem_addr=addr_r.
  - SM: rf_rd_addr=idx, mem_din=rf_rd_data, mem_load=1.
  - LM: rf_wr_en=1, rf_wr_addr=idx, rf_wr_data=mem_dout.
  - At the edge: clear bit idx, addr_r<=addr_r+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000). If the cleared mask is 0, go to DONE (or WB with macro).
- DONE: done=1 for exactly one cycle, then IDLE. Outputs are idle-valued in DONE.
- Latency: N set bits -> N XFER cycles, done in cycle N+1 after the start edge. For mask=0, done occurs in the cycle after start.
- busy=1 in XFER/WB/DONE. start while busy=1 is ignored; no queueing.
- In non-transfer states mem_addr=addr_r, mem_load=0, rf_wr_en=0.
- Outputs are combinational from state/regs; RAM write commits at the same edge the transfer completes.
- Reset asserted mid-operation: at the next edge, return to IDLE with the remaining mask discarded. No done pulse.

Optional Feature:
LMSM_WRITEBACK_EN
- Defined: after the last transfer, enter WB for one cycle: rf_wr_en=1, rf_wr_addr=wb_reg (latched at start), rf_wr_data=addr_r (base+count, wrapped). Then DONE. The writeback overrides any LM load to the same register. For mask=0, WB writes base_addr. Latency grows by 1.
- Undefined: no WB state; wb_reg is ignored; timing as above.

Test Plan:
- SM: R0=0xAAAA, R2=0x5555, base=0x0010, mask=0x05 -> cycle1 mem_load=1 addr 0x0010 din 0xAAAA; cycle2 addr 0x0011 din 0x5555; cycle3 done=1; RAM[0x10..0x11] match.
- LM: RAM[0x20]=0x1234, RAM[0x21]=0xBEEF, base=0x0020, mask=0x81 -> R0=0x1234, R7=0xBEEF; mem_load never 1; done on cycle 3.
- mask=0x00, start -> done=1 on the next cycle; no mem_load or rf_wr_en pulses; busy high that cycle only.
- Wrap: SM base=0xFFFF, mask=0x03 -> addresses 0xFFFF then 0x0000.
- start pulsed while busy (mask=0xFF) -> ignored; exactly 8 transfers and one done. rst_n low during the 4th transfer -> strobes 0 that cycle; IDLE next; no done.
- With LMSM_WRITEBACK_EN: LM base=0x0040, mask=0x0E, wb_reg=1 -> R1 loaded then overwritten by 0x0043 in WB; done on cycle 5.
